// File: rtl/riscv_pipe_stage_reg.sv
// riscv_pipe_stage_reg: valid/ready pipeline register with flush-to-bubble and optional 2-entry skid buffer.
module riscv_pipe_stage_reg #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0,
   parameter bit               SKID         = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_flush
);
   logic             o_valid_q, o_valid_d, skid_valid_q, skid_valid_d, ready_q, ready_d;
   logic [WIDTH-1:0] data_q, data_d, skid_data_q, skid_data_d;
   logic             in_fire, out_fire, skid_we;
   assign o_ready  = SKID ? ready_q : (!o_valid_q || i_ready);
   assign o_valid  = o_valid_q;
   assign o_data   = data_q;
   assign in_fire  = i_valid && o_ready;
   assign out_fire = o_valid_q && i_ready;
   always_comb begin
      o_valid_d    = o_valid_q;
      data_d       = data_q;
      skid_valid_d = skid_valid_q;
      skid_we      = 1'b0;
      if (SKID) begin
         if (!o_valid_q || out_fire) begin
            o_valid_d    = skid_valid_q || in_fire;
            data_d       = skid_valid_q ? skid_data_q : (in_fire ? i_data : data_q);
            skid_we      = skid_valid_q && in_fire;
            skid_valid_d = skid_we;
         end else if (in_fire) begin
            skid_we      = 1'b1;
            skid_valid_d = 1'b1;
         end
      end else begin
         o_valid_d = in_fire || (o_valid_q && !out_fire);
         data_d    = in_fire ? i_data : data_q;
      end
      skid_data_d = skid_we ? i_data : skid_data_q;
      ready_d     = !skid_valid_d;
      // flush outranks everything, including an in_fire in the same cycle
      if (i_flush) begin
         o_valid_d    = 1'b0;
         skid_valid_d = 1'b0;
         data_d       = BUBBLE_VALUE;
         skid_data_d  = BUBBLE_VALUE;
         ready_d      = 1'b1;
      end
   end
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_valid_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
         data_q       <= BUBBLE_VALUE;
         skid_data_q  <= BUBBLE_VALUE;
      end else begin
         o_valid_q    <= o_valid_d;
         skid_valid_q <= skid_valid_d;
         ready_q      <= ready_d;
         data_q       <= data_d;
         skid_data_q  <= skid_data_d;
      end
   end
   a_skid_no_overwrite: assert property (@(posedge i_clk) disable iff (!i_rstn) !(skid_valid_q && in_fire));
   a_flush_kills: assert property (@(posedge i_clk) disable iff (!i_rstn) i_flush |=> !o_valid);
endmodule

// File: tb/tb_riscv_pipe_stage_reg.sv
// tb_riscv_pipe_stage_reg: directed and scoreboard checks of both skid modes.
module tb_riscv_pipe_stage_reg;
   logic        clk = 1'b0, rstn = 1'b0;
   logic        valid = 1'b0, ready = 1'b0, flush = 1'b0;
   logic [31:0] data = '0;
   logic        ready1, valid1, ready0, valid0;
   logic [31:0] data1, data0;
   int          errors = 0, checks = 0;

   always #5 clk = ~clk;

   riscv_pipe_stage_reg #(.WIDTH(32), .SKID(1'b1)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(ready1), .i_data(data),
      .o_valid(valid1), .i_ready(ready), .o_data(data1), .i_flush(flush));
   riscv_pipe_stage_reg #(.WIDTH(32), .SKID(1'b0)) dut0 (
      .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .o_ready(ready0), .i_data(data),
      .o_valid(valid0), .i_ready(ready), .o_data(data0), .i_flush(flush));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      rstn = 1'b0; valid = 1'b0; ready = 1'b0; flush = 1'b0; data = '0;
      #2;
      checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1 got %b exp 0", valid1); end
      checks++; if (data1 !== 32'h0) begin errors++; $display("FAIL reset_data1 got %h exp 0", data1); end
      checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b exp 1", ready1); end
      checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b exp 0", valid0); end
      tick();
      rstn = 1'b1;
      #1;
      checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL post_reset_ready1 got %b exp 1", ready1); end
   endtask

   task automatic test_stream();
      logic [31:0] v [3];
      v[0] = 32'h11; v[1] = 32'h22; v[2] = 32'h33;
      ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1; data = v[i];
         tick();
         checks++; if (valid1 !== 1'b1 || data1 !== v[i]) begin errors++; $display("FAIL stream_%0d got v=%b d=%h exp v=1 d=%h", i, valid1, data1, v[i]); end
         checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got %b exp 1", i, ready1); end
      end
      valid = 1'b0;
      tick();
      checks++; if (valid1 !== 1'b0 || data1 !== 32'h33) begin errors++; $display("FAIL stream_drain got v=%b d=%h exp v=0 d=33", valid1, data1); end
   endtask

   task automatic test_stall_fill();
      ready = 1'b0;
      valid = 1'b1; data = 32'hA;
      tick();
      checks++; if (valid1 !== 1'b1 || data1 !== 32'hA || ready1 !== 1'b1) begin errors++; $display("FAIL stall_a got v=%b d=%h r=%b exp v=1 d=a r=1", valid1, data1, ready1); end
      data = 32'hB;
      tick();
      checks++; if (data1 !== 32'hA || ready1 !== 1'b0) begin errors++; $display("FAIL stall_b got d=%h r=%b exp d=a r=0", data1, ready1); end
      data = 32'hC;
      tick();
      checks++; if (valid1 !== 1'b1 || data1 !== 32'hA || ready1 !== 1'b0) begin errors++; $display("FAIL stall_hold got v=%b d=%h r=%b exp v=1 d=a r=0", valid1, data1, ready1); end
      ready = 1'b1;
      tick();
      checks++; if (valid1 !== 1'b1 || data1 !== 32'hB || ready1 !== 1'b1) begin errors++; $display("FAIL stall_out_b got v=%b d=%h r=%b exp v=1 d=b r=1", valid1, data1, ready1); end
      tick();
      checks++; if (valid1 !== 1'b1 || data1 !== 32'hC) begin errors++; $display("FAIL stall_out_c got v=%b d=%h exp v=1 d=c", valid1, data1); end
      valid = 1'b0;
      tick();
      checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL stall_empty got v=%b exp 0", valid1); end
   endtask

   task automatic test_flush();
      ready = 1'b0; valid = 1'b1; data = 32'h5;
      tick();
      data = 32'h6;
      tick();
      checks++; if (ready1 !== 1'b0 || data1 !== 32'h5) begin errors++; $display("FAIL flush_setup got r=%b d=%h exp r=0 d=5", ready1, data1); end
      flush = 1'b1; data = 32'h7;
      tick();
      checks++; if (valid1 !== 1'b0 || data1 !== 32'h0 || ready1 !== 1'b1) begin errors++; $display("FAIL flush got v=%b d=%h r=%b exp v=0 d=0 r=1", valid1, data1, ready1); end
      checks++; if (valid0 !== 1'b0 || data0 !== 32'h0 || ready0 !== 1'b1) begin errors++; $display("FAIL flush0 got v=%b d=%h r=%b exp v=0 d=0 r=1", valid0, data0, ready0); end
      flush = 1'b0; valid = 1'b0; ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL flush_ghost_%0d got v=%b d=%h exp v=0", i, valid1, data1); end
      end
   endtask

   task automatic test_skid0();
      ready = 1'b0; valid = 1'b1; data = 32'h44;
      #1;
      checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL s0_empty_ready got %b exp 1", ready0); end
      tick();
      checks++; if (valid0 !== 1'b1 || data0 !== 32'h44) begin errors++; $display("FAIL s0_load got v=%b d=%h exp v=1 d=44", valid0, data0); end
      data = 32'h55;
      #1;
      checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL s0_bp_ready got %b exp 0", ready0); end
      ready = 1'b1;
      #1;
      checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL s0_comb_ready got %b exp 1", ready0); end
      tick();
      checks++; if (valid0 !== 1'b1 || data0 !== 32'h55) begin errors++; $display("FAIL s0_next got v=%b d=%h exp v=1 d=55", valid0, data0); end
      valid = 1'b0;
      tick();
      checks++; if (valid0 !== 1'b0 || data0 !== 32'h55) begin errors++; $display("FAIL s0_stale got v=%b d=%h exp v=0 d=55", valid0, data0); end
   endtask

   task automatic test_async_reset();
      ready = 1'b0; valid = 1'b1; data = 32'hDEAD;
      tick();
      data = 32'hBEEF;
      tick();
      valid = 1'b0;
      checks++; if (data1 !== 32'hDEAD || ready1 !== 1'b0) begin errors++; $display("FAIL ar_setup got d=%h r=%b exp d=dead r=0", data1, ready1); end
      #2;
      rstn = 1'b0;
      #1;
      checks++; if (valid1 !== 1'b0 || data1 !== 32'h0 || ready1 !== 1'b1) begin errors++; $display("FAIL ar_async got v=%b d=%h r=%b exp v=0 d=0 r=1", valid1, data1, ready1); end
      tick();
      rstn = 1'b1; ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL ar_stale_%0d got v=%b d=%h exp v=0", i, valid1, data1); end
      end
   endtask

   task automatic test_soak();
      logic [31:0] q1[$], q0[$];
      logic        in1, out1, in0, out0;
      for (int c = 0; c < 10000; c++) begin
         valid = ($urandom_range(0, 3) != 0);
         ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 31) == 0);
         data  = $urandom;
         #1;
         checks++; if (valid1 !== (q1.size() != 0) || ready1 !== (q1.size() < 2) || (q1.size() != 0 && data1 !== q1[0])) begin
            errors++; $display("FAIL soak1 cyc %0d got v=%b r=%b d=%h exp n=%0d d=%h", c, valid1, ready1, data1, q1.size(), q1.size() != 0 ? q1[0] : 32'h0);
         end
         checks++; if (valid0 !== (q0.size() != 0) || (q0.size() != 0 && data0 !== q0[0])) begin
            errors++; $display("FAIL soak0 cyc %0d got v=%b d=%h exp n=%0d d=%h", c, valid0, data0, q0.size(), q0.size() != 0 ? q0[0] : 32'h0);
         end
         in1 = valid && (q1.size() < 2);
         out1 = (q1.size() != 0) && ready;
         out0 = (q0.size() != 0) && ready;
         in0 = valid && (q0.size() == 0 || ready);
         if (out1) void'(q1.pop_front());
         if (out0) void'(q0.pop_front());
         if (flush) begin
            q1.delete(); q0.delete();
         end else begin
            if (in1) q1.push_back(data);
            if (in0) q0.push_back(data);
         end
         @(posedge clk);
         #1;
      end
      valid = 1'b0; flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall_fill();
      test_flush();
      test_reset();
      test_skid0();
      test_reset();
      test_async_reset();
      test_reset();
      test_soak();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/riscv_pipe_stage_reg.md
Name: riscv_pipe_stage_reg

Overview:
Parametrised pipeline stage register for the RISC-V core. It replaces the fixed-field, always-load inter-stage registers with one flat payload vector carried under a valid/ready handshake. It supports stall through downstream back-pressure, synchronous flush with bubble insertion, and an optional 2-entry skid buffer that registers o_ready. It is instantiated between IF/ID/EX/MEM/WB; stage-specific fields are concatenated into i_data by the parent.

Parameters:
WIDTH, 32, payload width in bits (1..512).
BUBBLE_VALUE, 0, payload value loaded on reset and on flush; must decode as a NOP/no-side-effect bundle.
SKID, 1, 1 = 2-entry skid buffer with registered o_ready; 0 = single entry with combinational o_ready.

Ports:
i_clk  in  1  clock, rising edge.
i_rstn  in  1  asynchronous active-low reset.
i_valid  in  1  upstream payload valid.
o_ready  out  1  stage can accept i_data this cycle.
i_data  in  WIDTH  upstream payload.
o_valid  out  1  o_data holds a live payload.
i_ready  in  1  downstream accepts o_data (low = stall).
o_data  out  WIDTH  registered payload to the next stage.
i_flush  in  1  synchronous kill of all held payloads.

Behaviour:
- Reset is asynchronous, active-low on i_rstn; clock is i_clk. Reset values: o_valid=0, o_data=BUBBLE_VALUE, skid_valid=0, skid_data=BUBBLE_VALUE. With SKID=1, o_ready=1 immediately after reset.
- An input transfer (in_fire) occurs when i_valid && o_ready. An output transfer (out_fire) occurs when o_valid && i_ready.
- Latency is 1 cycle from in_fire to o_valid when the stage is empty.
- SKID=0:
  - o_ready = !o_valid || i_ready (combinational).
  - Main register loads i_data on in_fire.
  - If there is no in_fire but there is an out_fire, o_valid clears to 0.
  - o_data holds its last value when it is not loaded.
- SKID=1:
  - o_ready = !skid_valid, driven only by a register.
  - Main register loads when it is empty or on out_fire. The source is skid_data if skid_valid=1, otherwise i_data on in_fire.
  - If the main register is full and there is no out_fire, an in_fire writes into the skid entry (skid_valid<=1).
  - If the skid entry drains into the main register and an in_fire occurs in the same cycle, the new i_data goes into the skid entry. Order is preserved.
  - The skid entry is never written while it is full; this is guaranteed because o_ready=0.
- Ordering: payloads leave in exactly the order they were accepted. There is no duplication and no loss except on flush.
- Stall: with i_ready held low, o_valid and o_data stay constant. Once all entries are full, o_ready=0 (SKID=1) or tracks i_ready (SKID=0).
- Flush:
  - i_flush=1 has the highest priority. At the next edge: o_valid=0, skid_valid=0, o_data=BUBBLE_VALUE, skid_data=BUBBLE_VALUE.
  - Any in_fire in the flush cycle is discarded. Upstream is flushed by the same hazard unit.
  - An out_fire in the flush cycle still counts as completed downstream; flush does not recall it.
  - o_ready is not gated by i_flush. After the flush edge o_ready=1 for both modes.
- Simultaneous in_fire and out_fire with a full main register and empty skid: main loads i_data, skid stays empty.
- Bubble visibility: o_data equals BUBBLE_VALUE only after reset or flush. A drain without refill leaves the stale value with o_valid=0; consumers must qualify with o_valid.
- Reset asserted mid-transfer clears all state asynchronously. No payload survives; o_ready returns to 1 (SKID=1) while i_rstn is low.
- Synthesisable. No latches, no X on any output after reset. Assertions: skid is never written while full, and o_valid is never 1 after a flush edge.

Test Plan:
- Reset then stream: WIDTH=32, SKID=1, i_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> o_valid=1 from cycle 1, o_data 0x11,0x22,0x33 on cycles 1..3, o_ready stays 1.
- Stall fill: i_ready=0, push 0xA,0xB,0xC -> 0xA in main, 0xB in skid, o_ready=0 after 2nd accept, 0xC held upstream; raise i_ready -> outputs 0xA,0xB,0xC in order with no gaps.
- Flush with skid full: main=0x5, skid=0x6, assert i_flush with i_valid=1 data 0x7 -> next cycle o_valid=0, o_data=BUBBLE_VALUE (0), o_ready=1; 0x7 never appears.
- SKID=0 back-pressure: main full, i_ready=0, i_valid=1 -> o_ready=0 combinationally; i_ready=1 the same cycle -> o_ready=1, new data appears next cycle.
- Async reset mid-stall: main=0xDEAD, skid=0xBEEF, drop i_rstn between edges -> o_valid=0 and o_data=0 without a clock; after release, no stale payload is emitted.
- Random soak: random i_valid/i_ready/i_flush for 10k cycles against a scoreboard FIFO -> output order matches, and no loss occurs except payloads killed by flush.
